// File: rtl/dc_huffman_cozucu.sv
// Serial JPEG baseline DC decoder: walks the luma/chroma DC Huffman code one bit at a time,
// then collects the magnitude bits. Optional macro DC_TAHMIN_EN adds per-component DC predictors.
module dc_huffman_cozucu #(
    parameter int DEGER_W  = 12,
    parameter int MAKS_KAT = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               bit_i,
    input  logic               bit_gecerli_i,
    output logic               bit_hazir_o,
    input  logic [1:0]         kanal_i,
    input  logic               tahmin_sifirla_i,
    output logic               cikis_gecerli_o,
    input  logic               cikis_hazir_i,
    output logic [3:0]         kategori_o,
    output logic [DEGER_W-1:0] fark_o,
    output logic [DEGER_W-1:0] dc_o,
    output logic [1:0]         kanal_o,
    output logic               hata_o
);

    // Handshakes: a bit moves on bit_gecerli_i & bit_hazir_o; a result moves on
    // cikis_gecerli_o & cikis_hazir_i. Both are sampled on the rising clock edge.
    typedef enum logic [1:0] {KOD = 2'd0, EK = 2'd1, CIKIS = 2'd2} durum_t;

    durum_t             durum_q, durum_d;
    logic [10:0]        kod_q, kod_d;
    logic [3:0]         uzun_q, uzun_d;
    logic [1:0]         kanal_q, kanal_d;
    logic [3:0]         kalan_q, kalan_d;
    logic [3:0]         kat_q, kat_d;
    logic [9:0]         v_q, v_d;
    logic [3:0]         kategori_q, kategori_d;
    logic [DEGER_W-1:0] fark_q, fark_d;
    logic [1:0]         kanal_out_q, kanal_out_d;
    logic               hata_q, hata_d;

    logic [10:0]        kod_n;
    logic [3:0]         uzun_n;
    logic [1:0]         kanal_sel;
    logic [10:0]        uzun_maske;
    logic               onek_bir;
    logic               eslesme;
    logic [3:0]         eslesen_kat;
    logic               kod_hata;
    logic [10:0]        v_n;
    logic [DEGER_W-1:0] v_ext;
    logic [DEGER_W-1:0] ek_maske;
    logic               sonuc_yaz;
    logic [DEGER_W-1:0] sonuc_fark;
    logic [3:0]         sonuc_kat;
    logic [1:0]         sonuc_kanal;

    // Table lookup for the code as it would be after accepting bit_i.
    always_comb begin
        kod_n       = {kod_q[9:0], bit_i};
        uzun_n      = uzun_q + 4'd1;
        kanal_sel   = (uzun_q == 4'd0) ? kanal_i : kanal_q;
        uzun_maske  = (11'd1 << uzun_q) - 11'd1;
        // All previously accepted code bits are ones (true for an empty code).
        onek_bir    = &(kod_q | ~uzun_maske);
        eslesme     = 1'b0;
        eslesen_kat = 4'd0;
        kod_hata    = 1'b0;
        if (kanal_sel == 2'd3) begin
            kod_hata = 1'b1;
        end else if (kanal_sel == 2'd0) begin
            if (uzun_n == 4'd2 && kod_n[1:0] == 2'b00) begin
                eslesme = 1'b1;
            end else if (uzun_n == 4'd3 && kod_n[2:0] != 3'b111) begin
                eslesme     = 1'b1;
                eslesen_kat = {1'b0, kod_n[2:0]} - 4'd1;
            end else if (uzun_n >= 4'd4 && onek_bir && !bit_i) begin
                eslesme     = 1'b1;
                eslesen_kat = uzun_n + 4'd2;
            end else if (uzun_n == 4'd9 && onek_bir && bit_i) begin
                kod_hata = 1'b1;
            end
        end else begin
            if (uzun_n == 4'd2 && kod_n[1:0] != 2'b11) begin
                eslesme     = 1'b1;
                eslesen_kat = {2'b00, kod_n[1:0]};
            end else if (uzun_n >= 4'd3 && onek_bir && !bit_i) begin
                eslesme     = 1'b1;
                eslesen_kat = uzun_n;
            end else if (uzun_n == 4'd11 && onek_bir && bit_i) begin
                kod_hata = 1'b1;
            end
        end
        if (eslesme && int'(eslesen_kat) > MAKS_KAT) begin
            kod_hata = 1'b1;
        end
    end

    // Magnitude: a leading 0 marks a negative difference, V - (2^k - 1).
    always_comb begin
        v_n      = {v_q, bit_i};
        v_ext    = DEGER_W'(v_n);
        ek_maske = (DEGER_W'(1) << kat_q) - DEGER_W'(1);
    end

    always_comb begin
        durum_d     = durum_q;
        kod_d       = kod_q;
        uzun_d      = uzun_q;
        kanal_d     = kanal_q;
        kalan_d     = kalan_q;
        kat_d       = kat_q;
        v_d         = v_q;
        hata_d      = 1'b0;
        sonuc_yaz   = 1'b0;
        sonuc_fark  = '0;
        sonuc_kat   = 4'd0;
        sonuc_kanal = kanal_q;
        unique case (durum_q)
            KOD: begin
                if (bit_gecerli_i) begin
                    kod_d   = kod_n;
                    uzun_d  = uzun_n;
                    kanal_d = kanal_sel;
                    if (kod_hata) begin
                        hata_d  = 1'b1;
                        kod_d   = '0;
                        uzun_d  = 4'd0;
                        kanal_d = 2'd0;
                    end else if (eslesme) begin
                        kod_d  = '0;
                        uzun_d = 4'd0;
                        if (eslesen_kat == 4'd0) begin
                            sonuc_yaz   = 1'b1;
                            sonuc_kanal = kanal_sel;
                            durum_d     = CIKIS;
                        end else begin
                            kalan_d = eslesen_kat;
                            kat_d   = eslesen_kat;
                            v_d     = '0;
                            durum_d = EK;
                        end
                    end
                end
            end
            EK: begin
                if (bit_gecerli_i) begin
                    v_d     = v_n[9:0];
                    kalan_d = kalan_q - 4'd1;
                    if (kalan_q == 4'd1) begin
                        sonuc_yaz  = 1'b1;
                        sonuc_kat  = kat_q;
                        sonuc_fark = v_n[kat_q - 4'd1] ? v_ext : (v_ext - ek_maske);
                        durum_d    = CIKIS;
                    end
                end
            end
            CIKIS: begin
                if (cikis_hazir_i) begin
                    durum_d = KOD;
                end
            end
            default: durum_d = KOD;
        endcase
        kategori_d  = sonuc_yaz ? sonuc_kat : kategori_q;
        fark_d      = sonuc_yaz ? sonuc_fark : fark_q;
        kanal_out_d = sonuc_yaz ? sonuc_kanal : kanal_out_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q     <= KOD;
            kod_q       <= '0;
            uzun_q      <= 4'd0;
            kanal_q     <= 2'd0;
            kalan_q     <= 4'd0;
            kat_q       <= 4'd0;
            v_q         <= '0;
            kategori_q  <= 4'd0;
            fark_q      <= '0;
            kanal_out_q <= 2'd0;
            hata_q      <= 1'b0;
        end else begin
            durum_q     <= durum_d;
            kod_q       <= kod_d;
            uzun_q      <= uzun_d;
            kanal_q     <= kanal_d;
            kalan_q     <= kalan_d;
            kat_q       <= kat_d;
            v_q         <= v_d;
            kategori_q  <= kategori_d;
            fark_q      <= fark_d;
            kanal_out_q <= kanal_out_d;
            hata_q      <= hata_d;
        end
    end

`ifdef DC_TAHMIN_EN
    logic [DEGER_W-1:0] tahmin_q [3];
    logic [DEGER_W-1:0] tahmin_d [3];
    logic [DEGER_W-1:0] dc_q, dc_d;

    // A restart clear applies before the commit, so a coinciding result starts from zero.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tahmin_d[i] = tahmin_sifirla_i ? '0 : tahmin_q[i];
        end
        dc_d = dc_q;
        if (sonuc_yaz) begin
            case (sonuc_kanal)
                2'd0: begin dc_d = tahmin_d[0] + sonuc_fark; tahmin_d[0] = dc_d; end
                2'd1: begin dc_d = tahmin_d[1] + sonuc_fark; tahmin_d[1] = dc_d; end
                2'd2: begin dc_d = tahmin_d[2] + sonuc_fark; tahmin_d[2] = dc_d; end
                default: dc_d = sonuc_fark;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dc_q <= '0;
            for (int i = 0; i < 3; i++) begin
                tahmin_q[i] <= '0;
            end
        end else begin
            dc_q <= dc_d;
            for (int i = 0; i < 3; i++) begin
                tahmin_q[i] <= tahmin_d[i];
            end
        end
    end

    assign dc_o = dc_q;
`else
    logic unused_tahmin_sifirla;
    assign unused_tahmin_sifirla = tahmin_sifirla_i;
    assign dc_o = fark_q;
`endif

    assign bit_hazir_o     = (durum_q != CIKIS);
    assign cikis_gecerli_o = (durum_q == CIKIS);
    assign kategori_o      = kategori_q;
    assign fark_o          = fark_q;
    assign kanal_o         = kanal_out_q;
    assign hata_o          = hata_q;

endmodule

// File: tb/tb_dc_huffman_cozucu.sv
// Directed bench for dc_huffman_cozucu: code tables, magnitude sign handling, back-pressure,
// illegal codes, reset mid-block, and the DC predictors when DC_TAHMIN_EN is defined.
module tb_dc_huffman_cozucu;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         bit_i;
    logic         bit_gecerli_i;
    logic         bit_hazir_o;
    logic [1:0]   kanal_i;
    logic         tahmin_sifirla_i;
    logic         cikis_gecerli_o;
    logic         cikis_hazir_i;
    logic [3:0]   kategori_o;
    logic [W-1:0] fark_o;
    logic [W-1:0] dc_o;
    logic [1:0]   kanal_o;
    logic         hata_o;

    int checks = 0;
    int errors = 0;

    dc_huffman_cozucu #(.DEGER_W(W), .MAKS_KAT(11)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .bit_i            (bit_i),
        .bit_gecerli_i    (bit_gecerli_i),
        .bit_hazir_o      (bit_hazir_o),
        .kanal_i          (kanal_i),
        .tahmin_sifirla_i (tahmin_sifirla_i),
        .cikis_gecerli_o  (cikis_gecerli_o),
        .cikis_hazir_i    (cikis_hazir_i),
        .kategori_o       (kategori_o),
        .fark_o           (fark_o),
        .dc_o             (dc_o),
        .kanal_o          (kanal_o),
        .hata_o           (hata_o)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic pulse_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    // Drivers: inputs change 1 ns after the rising edge, outputs are read there too.
    task automatic send_bit(input logic b, input logic [1:0] k);
        int n;
        n = 0;
        bit_i = b;
        kanal_i = k;
        bit_gecerli_i = 1'b1;
        while (bit_hazir_o !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("FAIL send_bit_timeout: bit_hazir_o=%b, required 1 within 20 cycles", bit_hazir_o);
        end
        @(posedge clk);
        #1 bit_gecerli_i = 1'b0;
    endtask

    task automatic send_bits(input logic [10:0] val, input int n, input logic [1:0] k);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(val[i], k);
        end
    endtask

    task automatic consume();
        cikis_hazir_i = 1'b1;
        @(posedge clk);
        #1 cikis_hazir_i = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++; if (cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cikis_gecerli_o); end
        checks++; if (kategori_o !== 4'd0) begin errors++; $display("FAIL reset_kategori: got %0d want 0", kategori_o); end
        checks++; if (fark_o !== 12'h000) begin errors++; $display("FAIL reset_fark: got %h want 000", fark_o); end
        checks++; if (dc_o !== 12'h000) begin errors++; $display("FAIL reset_dc: got %h want 000", dc_o); end
        checks++; if (kanal_o !== 2'd0) begin errors++; $display("FAIL reset_kanal: got %0d want 0", kanal_o); end
        checks++; if (hata_o !== 1'b0) begin errors++; $display("FAIL reset_hata: got %b want 0", hata_o); end
        checks++; if (bit_hazir_o !== 1'b1) begin errors++; $display("FAIL reset_bit_hazir: got %b want 1", bit_hazir_o); end
    endtask

    task automatic test_kategori0();
        send_bit(1'b0, 2'd0);
        checks++; if (cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL kat0_early_valid: got %b want 0", cikis_gecerli_o); end
        send_bit(1'b0, 2'd0);
        checks++; if (cikis_gecerli_o !== 1'b1) begin errors++; $display("FAIL kat0_valid: got %b want 1", cikis_gecerli_o); end
        checks++; if (kategori_o !== 4'd0) begin errors++; $display("FAIL kat0_kategori: got %0d want 0", kategori_o); end
        checks++; if (fark_o !== 12'h000) begin errors++; $display("FAIL kat0_fark: got %h want 000", fark_o); end
        checks++; if (kanal_o !== 2'd0) begin errors++; $display("FAIL kat0_kanal: got %0d want 0", kanal_o); end
        consume();
        checks++; if (cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL kat0_after_consume: got %b want 0", cikis_gecerli_o); end
    endtask

    task automatic test_luma_negative();
        send_bits(11'b101, 3, 2'd0);
        checks++; if (cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL luma4_code_valid: got %b want 0", cikis_gecerli_o); end
        send_bits(11'b0110, 4, 2'd0);
        checks++; if (cikis_gecerli_o !== 1'b1) begin errors++; $display("FAIL luma4_valid: got %b want 1", cikis_gecerli_o); end
        checks++; if (kategori_o !== 4'd4) begin errors++; $display("FAIL luma4_kategori: got %0d want 4", kategori_o); end
        checks++; if (fark_o !== 12'hFF7) begin errors++; $display("FAIL luma4_fark: got %h want ff7", fark_o); end
`ifndef DC_TAHMIN_EN
        checks++; if (dc_o !== 12'hFF7) begin errors++; $display("FAIL luma4_dc: got %h want ff7", dc_o); end
`endif
        consume();
    endtask

    task automatic test_chroma_table();
        // kanal_i changes after the first bit; the block must keep the chroma table.
        send_bit(1'b1, 2'd1);
        send_bits(11'b10, 2, 2'd0);
        send_bits(11'b101, 3, 2'd0);
        checks++; if (cikis_gecerli_o !== 1'b1) begin errors++; $display("FAIL chroma3_valid: got %b want 1", cikis_gecerli_o); end
        checks++; if (kategori_o !== 4'd3) begin errors++; $display("FAIL chroma3_kategori: got %0d want 3", kategori_o); end
        checks++; if (fark_o !== 12'h005) begin errors++; $display("FAIL chroma3_fark: got %h want 005", fark_o); end
        checks++; if (kanal_o !== 2'd1) begin errors++; $display("FAIL chroma3_kanal: got %0d want 1", kanal_o); end
        consume();
        send_bits(11'b110, 3, 2'd0);
        send_bits(11'b10101, 5, 2'd0);
        checks++; if (kategori_o !== 4'd5) begin errors++; $display("FAIL luma5_kategori: got %0d want 5", kategori_o); end
        checks++; if (fark_o !== 12'h015) begin errors++; $display("FAIL luma5_fark: got %h want 015", fark_o); end
        checks++; if (kanal_o !== 2'd0) begin errors++; $display("FAIL luma5_kanal: got %0d want 0", kanal_o); end
        consume();
    endtask

    task automatic test_gaps();
        // 100 -> category 3, magnitude 011 -> 3 - 7 = -4, with idle cycles between bits.
        send_bit(1'b1, 2'd0);
        repeat (3) @(posedge clk);
        #0;
        send_bits(11'b00, 2, 2'd0);
        repeat (2) @(posedge clk);
        #0;
        send_bit(1'b0, 2'd0);
        @(posedge clk);
        send_bits(11'b11, 2, 2'd0);
        checks++; if (kategori_o !== 4'd3) begin errors++; $display("FAIL gap_kategori: got %0d want 3", kategori_o); end
        checks++; if (fark_o !== 12'hFFC) begin errors++; $display("FAIL gap_fark: got %h want ffc", fark_o); end
    endtask

    task automatic test_backpressure();
        // Entered with the previous result (fark ffc) still pending.
        bit_i = 1'b0;
        kanal_i = 2'd0;
        bit_gecerli_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (cikis_gecerli_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, cikis_gecerli_o); end
            checks++; if (bit_hazir_o !== 1'b0) begin errors++; $display("FAIL bp_bit_hazir[%0d]: got %b want 0", i, bit_hazir_o); end
            checks++; if (fark_o !== 12'hFFC) begin errors++; $display("FAIL bp_fark[%0d]: got %h want ffc", i, fark_o); end
        end
        cikis_hazir_i = 1'b1;
        @(posedge clk);
        #1;
        cikis_hazir_i = 1'b0;
        bit_gecerli_i = 1'b0;
        checks++; if (bit_hazir_o !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", bit_hazir_o); end
        send_bit(1'b0, 2'd0);
        checks++; if (cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL bp_stray_bit: got %b want 0", cikis_gecerli_o); end
        send_bit(1'b0, 2'd0);
        checks++; if (cikis_gecerli_o !== 1'b1 || kategori_o !== 4'd0) begin errors++; $display("FAIL bp_next: valid %b kategori %0d want 1/0", cikis_gecerli_o, kategori_o); end
        consume();
    endtask

    task automatic test_errors();
        send_bits(11'b11111111, 8, 2'd0);
        checks++; if (hata_o !== 1'b0) begin errors++; $display("FAIL err_luma_early: got %b want 0", hata_o); end
        send_bit(1'b1, 2'd0);
        checks++; if (hata_o !== 1'b1 || cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL err_luma: hata %b valid %b want 1/0", hata_o, cikis_gecerli_o); end
        @(posedge clk);
        #1;
        checks++; if (hata_o !== 1'b0 || cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL err_luma_pulse: hata %b valid %b want 0/0", hata_o, cikis_gecerli_o); end
        send_bits(11'b00, 2, 2'd0);
        checks++; if (cikis_gecerli_o !== 1'b1 || kategori_o !== 4'd0) begin errors++; $display("FAIL err_luma_recover: valid %b kategori %0d want 1/0", cikis_gecerli_o, kategori_o); end
        consume();
        send_bits(11'b1111111111, 10, 2'd2);
        checks++; if (hata_o !== 1'b0) begin errors++; $display("FAIL err_chroma_early: got %b want 0", hata_o); end
        send_bit(1'b1, 2'd2);
        checks++; if (hata_o !== 1'b1 || cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL err_chroma: hata %b valid %b want 1/0", hata_o, cikis_gecerli_o); end
        send_bit(1'b0, 2'd3);
        checks++; if (hata_o !== 1'b1 || cikis_gecerli_o !== 1'b0) begin errors++; $display("FAIL err_kanal3: hata %b valid %b want 1/0", hata_o, cikis_gecerli_o); end
        send_bits(11'b00, 2, 2'd1);
        checks++; if (cikis_gecerli_o !== 1'b1 || kanal_o !== 2'd1) begin errors++; $display("FAIL err_kanal3_recover: valid %b kanal %0d want 1/1", cikis_gecerli_o, kanal_o); end
        consume();
    endtask

    task automatic test_reset_in_ek();
        send_bits(11'b110, 3, 2'd0);
        send_bits(11'b11, 2, 2'd0);
        checks++; if (fark_o !== 12'h000 && kanal_o === 2'd1) begin end
        pulse_reset();
        checks++; if (cikis_gecerli_o !== 1'b0 || kategori_o !== 4'd0 || fark_o !== 12'h000 || kanal_o !== 2'd0) begin
            errors++; $display("FAIL rst_ek_outputs: valid %b kat %0d fark %h kanal %0d want all 0", cikis_gecerli_o, kategori_o, fark_o, kanal_o);
        end
        send_bits(11'b010, 3, 2'd0);
        send_bit(1'b1, 2'd0);
        checks++; if (cikis_gecerli_o !== 1'b1 || kategori_o !== 4'd1 || fark_o !== 12'h001) begin
            errors++; $display("FAIL rst_ek_recover: valid %b kat %0d fark %h want 1/1/001", cikis_gecerli_o, kategori_o, fark_o);
        end
        consume();
    endtask

`ifdef DC_TAHMIN_EN
    task automatic test_tahmin();
        pulse_reset();
        send_bits(11'b011, 3, 2'd2);
        checks++; if (dc_o !== 12'h001) begin errors++; $display("FAIL tahmin_k2_first: got %h want 001", dc_o); end
        consume();
        send_bits(11'b100101, 6, 2'd0);
        checks++; if (dc_o !== 12'h005) begin errors++; $display("FAIL tahmin_k0_dc5: got %h want 005", dc_o); end
        consume();
        send_bits(11'b1010110, 7, 2'd0);
        checks++; if (dc_o !== 12'hFFC) begin errors++; $display("FAIL tahmin_k0_dcffc: got %h want ffc", dc_o); end
        consume();
        send_bits(11'b00, 2, 2'd2);
        checks++; if (dc_o !== 12'h001) begin errors++; $display("FAIL tahmin_k2_kept: got %h want 001", dc_o); end
        consume();
        tahmin_sifirla_i = 1'b1;
        @(posedge clk);
        #1 tahmin_sifirla_i = 1'b0;
        send_bits(11'b00, 2, 2'd0);
        checks++; if (dc_o !== 12'h000) begin errors++; $display("FAIL tahmin_cleared: got %h want 000", dc_o); end
        consume();
        send_bits(11'b101011, 6, 2'd0);
        tahmin_sifirla_i = 1'b1;
        send_bit(1'b0, 2'd0);
        tahmin_sifirla_i = 1'b0;
        checks++; if (dc_o !== 12'hFF7) begin errors++; $display("FAIL tahmin_clear_commit: got %h want ff7", dc_o); end
        consume();
        send_bits(11'b00, 2, 2'd0);
        checks++; if (dc_o !== 12'hFF7) begin errors++; $display("FAIL tahmin_stored: got %h want ff7", dc_o); end
        consume();
    endtask
`endif

    initial begin
        rst_i = 1'b1;
        bit_i = 1'b0;
        bit_gecerli_i = 1'b0;
        kanal_i = 2'd0;
        tahmin_sifirla_i = 1'b0;
        cikis_hazir_i = 1'b0;
        test_reset();
        test_kategori0();
        test_luma_negative();
        test_chroma_table();
        test_gaps();
        test_backpressure();
        test_errors();
        test_reset_in_ek();
`ifdef DC_TAHMIN_EN
        test_tahmin();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dc_huffman_cozucu.md
Name: dc_huffman_cozucu

Overview:
Serial JPEG baseline DC-coefficient decoder. Takes one entropy-coded bit per handshake and walks the standard DC Huffman code (luma table K.3 or chroma table K.4, selected per block). It outputs the size category, then collects that many magnitude bits and produces the sign-extended DC difference. Sits between the bitstream unstuffer and the block coefficient buffer, and replaces the fixed-length, luma-only category lookup.

Parameters:
DEGER_W, 12, width of fark_o and dc_o; must be >= MAKS_KAT+1.
MAKS_KAT, 11, highest legal category (1..11); a decoded category above this is an error.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
bit_i  input  1  next bitstream bit, MSB-first
bit_gecerli_i  input  1  bit_i valid
bit_hazir_o  output  1  decoder accepts a bit this cycle
kanal_i  input  2  component of the block: 0=Y (luma table), 1=Cb, 2=Cr (chroma table), 3=reserved
tahmin_sifirla_i  input  1  clear DC predictors (restart marker); ignored unless DC_TAHMIN_EN
cikis_gecerli_o  output  1  result valid
cikis_hazir_i  input  1  consumer accepts the result
kategori_o  output  4  decoded size category 0..11
fark_o  output  DEGER_W  signed DC difference
dc_o  output  DEGER_W  DC value (see Optional Feature)
kanal_o  output  2  component of the result
hata_o  output  1  one-cycle pulse on an illegal code

Behaviour:
- Reset (async on rst_i=1): state KOD, all outputs 0, code shift register and counters cleared, predictors 0. A reset mid-code or mid-magnitude discards the partial result with no output.
- Bit transfer occurs when bit_gecerli_i & bit_hazir_o. bit_hazir_o=1 in KOD and EK, 0 in CIKIS.
- KOD: shift the accepted bit into the code register and increment the length counter (max 11). kanal_i is sampled with the first code bit only and held for the whole block.
- After each bit, match (code, length) against the table selected by the held kanal:
  - Luma: 00→0, 010→1, 011→2, 100→3, 101→4, 110→5, 1110→6, 11110→7, 111110→8, 1111110→9, 11111110→10, 111111110→11.
  - Chroma: 00→0, 01→1, 10→2, 110→3, 1110→4, 11110→5, 111110→6, 1111110→7, 11111110→8, 111111110→9, 1111111110→10, 11111111110→11.
- On a match with category 0: fark=0, go to CIKIS. On a match with category k>0: load k into the magnitude counter, go to EK.
- Error: luma 9 ones, chroma 11 ones, kanal 3 (on its first bit), or a match with category > MAKS_KAT. Response: hata_o=1 for one cycle, no result, return to KOD with registers cleared.
- EK: shift k magnitude bits into V. After the k-th bit, fark = V if V[k-1]=1, else V-(2^k-1), sign-extended to DEGER_W. Go to CIKIS.
- Latency: cikis_gecerli_o rises the cycle after the last bit (code or magnitude) is accepted.
- CIKIS: cikis_gecerli_o=1. kategori_o, fark_o, dc_o and kanal_o are held stable until cikis_hazir_i=1, then next state is KOD. There is one bubble cycle per result; bits are never accepted in CIKIS.
- bit_gecerli_i may drop between any two bits; state and counters are held.

Optional Feature:
DC_TAHMIN_EN defined:
- Three predictors of DEGER_W bits, one per kanal 0..2.
- On entry to CIKIS, dc_o = tahmin[kanal] + fark, modulo 2^DEGER_W, and the same value is written back to tahmin[kanal].
- tahmin_sifirla_i=1 clears all predictors synchronously. If it coincides with the commit cycle, the clear wins and the committed dc_o = 0 + fark, which is stored.
Not defined:
- dc_o = fark_o, no predictor registers, tahmin_sifirla_i is unused.

Test Plan:
- kanal 0, bits 0,0 → one cycle later cikis_gecerli_o=1, kategori 0, fark 0x000, kanal_o 0.
- kanal 0, bits 101 then 0110 → kategori 4, fark 6-15 = -9 = 0xFF7.
- kanal 1, bits 110 then 101 → kategori 3 (chroma table), fark 0x005. The same bits on kanal 0 give kategori 5.
- Hold cikis_hazir_i=0 for 5 cycles after a result → outputs stable and bit_hazir_o=0. Release → next bits accepted.
- kanal 0, nine 1-bits → hata_o pulses once with no cikis_gecerli_o. Then 0,0 decodes to kategori 0. Assert rst_i during EK → no result, outputs 0.
- DC_TAHMIN_EN, kanal 0: 100+101 (dc 5), then 101+0110 (dc 0xFFC), then tahmin_sifirla_i then 00 → dc 0. kanal 2 is unaffected throughout.
